// File: rtl/pipe_pkg.sv
// Shared Y86-64 encodings and the D-register bubble (nop) contents used by
// the fetch/decode pipeline registers.
package pipe_pkg;

  localparam logic [3:0] HALT = 4'h0;
  localparam logic [3:0] NOP  = 4'h1;
  localparam logic [3:0] JXX  = 4'h7;
  localparam logic [3:0] RET  = 4'h9;

  localparam logic [3:0] AOK = 4'h1;
  localparam logic [3:0] HLT = 4'h2;
  localparam logic [3:0] ADR = 4'h3;
  localparam logic [3:0] INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  // A bubble is a nop with no register operands and a clean status;
  // valC/valP of a bubble are zero at whatever PC width the user picks.
  localparam logic [3:0] BUBBLE_ICODE = NOP;
  localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
  localparam logic [3:0] BUBBLE_RA    = RNONE;
  localparam logic [3:0] BUBBLE_RB    = RNONE;
  localparam logic [3:0] BUBBLE_STAT  = AOK;

endpackage

// File: rtl/pipe_select_pc.sv
// Fetch PC selection: recovers from a mispredicted jXX first, then from a
// ret reaching writeback, otherwise follows the predicted PC.
module pipe_select_pc
  import pipe_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [3:0]      M_icode,
  input  logic            M_cnd,
  input  logic [PC_W-1:0] M_valA,
  input  logic [3:0]      W_icode,
  input  logic [PC_W-1:0] W_valM,
  input  logic [PC_W-1:0] F_predPC,
  output logic [PC_W-1:0] f_pc
);

  always_comb begin
    f_pc = F_predPC;
    if (M_icode == JXX && !M_cnd) begin
      f_pc = M_valA;
    end else if (W_icode == RET) begin
      f_pc = W_valM;
    end
  end

endmodule

// File: rtl/pipe_fetch_decode_regs.sv
// F (predicted PC) and D (fetched instruction) pipeline registers with
// stall/bubble control and saturating stall/bubble performance counters.
module pipe_fetch_decode_regs
  import pipe_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              CNT_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic [PC_W-1:0]  f_predPC,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [PC_W-1:0]  f_valC,
  input  logic [PC_W-1:0]  f_valP,
  input  logic [3:0]       f_stat,
  input  logic [3:0]       M_icode,
  input  logic             M_cnd,
  input  logic [PC_W-1:0]  M_valA,
  input  logic [3:0]       W_icode,
  input  logic [PC_W-1:0]  W_valM,
  output logic [PC_W-1:0]  f_pc,
  output logic [PC_W-1:0]  F_predPC,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [3:0]       D_rA,
  output logic [3:0]       D_rB,
  output logic [PC_W-1:0]  D_valC,
  output logic [PC_W-1:0]  D_valP,
  output logic [3:0]       D_stat,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [PC_W-1:0]  F_predPC_q, F_predPC_d;
  logic [3:0]       D_icode_q, D_icode_d;
  logic [3:0]       D_ifun_q, D_ifun_d;
  logic [3:0]       D_rA_q, D_rA_d;
  logic [3:0]       D_rB_q, D_rB_d;
  logic [PC_W-1:0]  D_valC_q, D_valC_d;
  logic [PC_W-1:0]  D_valP_q, D_valP_d;
  logic [3:0]       D_stat_q, D_stat_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  pipe_select_pc #(.PC_W(PC_W)) u_select_pc (
    .M_icode  (M_icode),
    .M_cnd    (M_cnd),
    .M_valA   (M_valA),
    .W_icode  (W_icode),
    .W_valM   (W_valM),
    .F_predPC (F_predPC_q),
    .f_pc     (f_pc)
  );

  always_comb begin
    F_predPC_d   = F_predPC_q;
    D_icode_d    = D_icode_q;
    D_ifun_d     = D_ifun_q;
    D_rA_d       = D_rA_q;
    D_rB_d       = D_rB_q;
    D_valC_d     = D_valC_q;
    D_valP_d     = D_valP_q;
    D_stat_d     = D_stat_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (!F_stall) begin
      F_predPC_d = f_predPC;
    end

    // Stall outranks bubble: a held instruction must not be squashed.
    if (!D_stall) begin
      if (D_bubble) begin
        D_icode_d = BUBBLE_ICODE;
        D_ifun_d  = BUBBLE_IFUN;
        D_rA_d    = BUBBLE_RA;
        D_rB_d    = BUBBLE_RB;
        D_valC_d  = '0;
        D_valP_d  = '0;
        D_stat_d  = BUBBLE_STAT;
      end else begin
        D_icode_d = f_icode;
        D_ifun_d  = f_ifun;
        D_rA_d    = f_rA;
        D_rB_d    = f_rB;
        D_valC_d  = f_valC;
        D_valP_d  = f_valP;
        D_stat_d  = f_stat;
      end
    end

    if (D_stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!D_stall && D_bubble && bubble_cnt_q != '1) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_predPC_q   <= RESET_PC;
      D_icode_q    <= BUBBLE_ICODE;
      D_ifun_q     <= BUBBLE_IFUN;
      D_rA_q       <= BUBBLE_RA;
      D_rB_q       <= BUBBLE_RB;
      D_valC_q     <= '0;
      D_valP_q     <= '0;
      D_stat_q     <= BUBBLE_STAT;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      F_predPC_q   <= F_predPC_d;
      D_icode_q    <= D_icode_d;
      D_ifun_q     <= D_ifun_d;
      D_rA_q       <= D_rA_d;
      D_rB_q       <= D_rB_d;
      D_valC_q     <= D_valC_d;
      D_valP_q     <= D_valP_d;
      D_stat_q     <= D_stat_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign F_predPC   = F_predPC_q;
  assign D_icode    = D_icode_q;
  assign D_ifun     = D_ifun_q;
  assign D_rA       = D_rA_q;
  assign D_rB       = D_rB_q;
  assign D_valC     = D_valC_q;
  assign D_valP     = D_valP_q;
  assign D_stat     = D_stat_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_fetch_decode_regs.sv
// Scoreboard bench for the F/D pipeline registers: a behavioural model pushes
// the expected F/D snapshot each cycle and the snapshot after the edge is popped.
module tb_pipe_fetch_decode_regs;
  import pipe_pkg::*;

  localparam int PC_W  = 64;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [PC_W-1:0] pred;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [PC_W-1:0] valc;
    logic [PC_W-1:0] valp;
    logic [3:0]      stat;
  } snap_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
  logic [PC_W-1:0]  f_predPC = '0, f_valC = '0, f_valP = '0;
  logic [3:0]       f_icode = '0, f_ifun = '0, f_rA = '0, f_rB = '0, f_stat = AOK;
  logic [3:0]       M_icode = NOP, W_icode = NOP;
  logic             M_cnd = 1'b0;
  logic [PC_W-1:0]  M_valA = '0, W_valM = '0;
  logic [PC_W-1:0]  f_pc, F_predPC, D_valC, D_valP;
  logic [3:0]       D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  int total = 0;
  int bad = 0;

  snap_t           obs;
  snap_t           m_snap;
  snap_t           sb[$];
  logic [CNT_W-1:0] m_stall, m_bubble;

  localparam snap_t RESET_SNAP = '{pred: '0, icode: NOP, ifun: 4'h0, ra: RNONE,
                                   rb: RNONE, valc: '0, valp: '0, stat: AOK};

  pipe_fetch_decode_regs #(.PC_W(PC_W), .CNT_W(CNT_W), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .f_predPC(f_predPC), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM), .f_pc(f_pc), .F_predPC(F_predPC),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC),
    .D_valP(D_valP), .D_stat(D_stat), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {F_predPC, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat};

  function automatic logic [PC_W-1:0] exp_fpc();
    if (M_icode == JXX && M_cnd == 1'b0) return M_valA;
    if (W_icode == RET) return W_valM;
    return m_snap.pred;
  endfunction

  task automatic model_reset();
    m_snap   = RESET_SNAP;
    m_stall  = '0;
    m_bubble = '0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance the model with the current inputs, queue its prediction, then clock the DUT.
  task automatic clock_cycle();
    if (!F_stall) m_snap.pred = f_predPC;
    if (!D_stall) begin
      if (D_bubble) m_snap = '{pred: m_snap.pred, icode: NOP, ifun: 4'h0, ra: RNONE,
                               rb: RNONE, valc: '0, valp: '0, stat: AOK};
      else m_snap = '{pred: m_snap.pred, icode: f_icode, ifun: f_ifun, ra: f_rA,
                      rb: f_rB, valc: f_valC, valp: f_valP, stat: f_stat};
    end
    if (D_stall && m_stall != 4'hF) m_stall = m_stall + 4'd1;
    if (!D_stall && D_bubble && m_bubble != 4'hF) m_bubble = m_bubble + 4'd1;
    sb.push_back(m_snap);
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [PC_W-1:0] pred, input logic [3:0] ic, input logic [3:0] fn,
                           input logic [3:0] ra, input logic [3:0] rb,
                           input logic [PC_W-1:0] vc, input logic [PC_W-1:0] vp,
                           input logic [3:0] st);
    f_predPC = pred; f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb;
    f_valC = vc; f_valP = vp; f_stat = st;
  endtask

  task automatic test_reset();
    snap_t e;
    do_reset();
    total++;
    if (obs !== RESET_SNAP || {stall_cnt, bubble_cnt} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_init got=%h cnt=%h exp=%h cnt=00", obs, {stall_cnt, bubble_cnt}, RESET_SNAP);
    end
    D_bubble = 1'b1;
    clock_cycle();
    D_bubble = 1'b0;
    set_fetch(64'h20, 4'h3, 4'h0, 4'h2, RNONE, 64'h10, 64'h0A, AOK);
    clock_cycle();
    D_stall = 1'b1;
    clock_cycle();
    D_stall = 1'b0;
    while (sb.size() > 1) void'(sb.pop_front());
    e = sb.pop_front();
    total++;
    if (obs !== e || {stall_cnt, bubble_cnt} !== {m_stall, m_bubble}) begin
      bad++;
      $display("[TB] FAIL reset_preload got=%h cnt=%h exp=%h cnt=%h", obs, {stall_cnt, bubble_cnt}, e, {m_stall, m_bubble});
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs !== RESET_SNAP || {stall_cnt, bubble_cnt} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_async got=%h cnt=%h exp=%h cnt=00", obs, {stall_cnt, bubble_cnt}, RESET_SNAP);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal_flow();
    snap_t e;
    set_fetch(64'h0A, 4'h3, 4'h0, 4'h2, RNONE, 64'h10, 64'h0A, AOK);
    clock_cycle();
    e = sb.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL normal_d got=%h exp=%h", obs, e);
    end
    total++;
    if (f_pc !== 64'h0A) begin
      bad++;
      $display("[TB] FAIL normal_fpc got=%h exp=%h", f_pc, 64'h0A);
    end
  endtask

  task automatic test_load_use();
    snap_t e;
    do_reset();
    set_fetch(64'h100, 4'h5, 4'h0, 4'h1, 4'h3, 64'h8, 64'h10A, AOK);
    clock_cycle();
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("[TB] FAIL loaduse_first got=%h exp=%h", obs, e); end
    F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1;
    set_fetch(64'h200, 4'h6, 4'h1, 4'h4, 4'h5, 64'h77, 64'h20B, AOK);
    clock_cycle();
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("[TB] FAIL loaduse_hold got=%h exp=%h", obs, e); end
    total++;
    if (stall_cnt !== 4'd1 || bubble_cnt !== 4'd0) begin
      bad++;
      $display("[TB] FAIL loaduse_cnt got=%h/%h exp=1/0", stall_cnt, bubble_cnt);
    end
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    clock_cycle();
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("[TB] FAIL loaduse_release got=%h exp=%h", obs, e); end
  endtask

  task automatic test_mispredict();
    snap_t e;
    logic [CNT_W-1:0] prev_bubble;
    M_icode = JXX; M_cnd = 1'b0; M_valA = 64'h40; W_icode = RET; W_valM = 64'h80;
    #1;
    total++;
    if (f_pc !== 64'h40) begin bad++; $display("[TB] FAIL mispredict_fpc got=%h exp=%h", f_pc, 64'h40); end
    M_cnd = 1'b1;
    #1;
    total++;
    if (f_pc !== exp_fpc()) begin bad++; $display("[TB] FAIL taken_ret_fpc got=%h exp=%h", f_pc, exp_fpc()); end
    M_cnd = 1'b0;
    prev_bubble = bubble_cnt;
    D_bubble = 1'b1;
    set_fetch(64'h50, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h52, AOK);
    clock_cycle();
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("[TB] FAIL mispredict_bubble got=%h exp=%h", obs, e); end
    total++;
    if (bubble_cnt !== prev_bubble + 4'd1) begin
      bad++;
      $display("[TB] FAIL mispredict_cnt got=%h exp=%h", bubble_cnt, prev_bubble + 4'd1);
    end
    D_bubble = 1'b0; M_icode = NOP; W_icode = NOP;
    #1;
    total++;
    if (f_pc !== m_snap.pred) begin bad++; $display("[TB] FAIL plain_fpc got=%h exp=%h", f_pc, m_snap.pred); end
  endtask

  task automatic test_ret();
    snap_t e;
    do_reset();
    set_fetch(64'h30, 4'h9, 4'h0, RNONE, RNONE, 64'h0, 64'h31, AOK);
    clock_cycle();
    void'(sb.pop_front());
    W_icode = RET; W_valM = 64'h80; M_icode = NOP;
    #1;
    total++;
    if (f_pc !== 64'h80) begin bad++; $display("[TB] FAIL ret_fpc got=%h exp=%h", f_pc, 64'h80); end
    F_stall = 1'b1; D_bubble = 1'b1;
    set_fetch(64'h99, 4'h4, 4'h0, 4'h1, 4'h1, 64'h5, 64'h9A, AOK);
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL ret_cycle%0d got=%h exp=%h", i, obs, e); end
    end
    total++;
    if (F_predPC !== 64'h30 || bubble_cnt !== 4'd3) begin
      bad++;
      $display("[TB] FAIL ret_hold got=%h/%h exp=%h/3", F_predPC, bubble_cnt, 64'h30);
    end
    F_stall = 1'b0; D_bubble = 1'b0; W_icode = NOP;
  endtask

  task automatic test_status_passthrough();
    snap_t e;
    logic [3:0] stats [4];
    stats = '{INS, ADR, HLT, AOK};
    for (int i = 0; i < 4; i++) begin
      set_fetch(64'h400 + 64'(i), HALT, 4'h0, RNONE, RNONE, 64'h0, 64'h401 + 64'(i), stats[i]);
      clock_cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e || D_stat !== stats[i]) begin
        bad++;
        $display("[TB] FAIL stat_pass%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    D_stall = 1'b1;
    for (int i = 0; i < 15; i++) clock_cycle();
    total++;
    if (stall_cnt !== 4'hF) begin bad++; $display("[TB] FAIL sat_reach got=%h exp=f", stall_cnt); end
    for (int i = 0; i < 3; i++) clock_cycle();
    total++;
    if (stall_cnt !== 4'hF || bubble_cnt !== 4'h0) begin
      bad++;
      $display("[TB] FAIL sat_hold got=%h/%h exp=f/0", stall_cnt, bubble_cnt);
    end
    D_stall = 1'b0;
    sb.delete();
  endtask

  task automatic test_back_to_back();
    snap_t e;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      set_fetch({$urandom, $urandom}, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(1, 4)));
      F_stall  = ($urandom_range(0, 3) == 0);
      D_stall  = ($urandom_range(0, 3) == 0);
      D_bubble = ($urandom_range(0, 3) == 0);
      M_icode  = ($urandom_range(0, 1) == 0) ? JXX : NOP;
      M_cnd    = 1'($urandom);
      M_valA   = {$urandom, $urandom};
      W_icode  = ($urandom_range(0, 1) == 0) ? RET : NOP;
      W_valM   = {$urandom, $urandom};
      #1;
      total++;
      if (f_pc !== exp_fpc()) begin bad++; $display("[TB] FAIL b2b_fpc%0d got=%h exp=%h", i, f_pc, exp_fpc()); end
      clock_cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e || {stall_cnt, bubble_cnt} !== {m_stall, m_bubble}) begin
        bad++;
        $display("[TB] FAIL b2b_d%0d got=%h cnt=%h exp=%h cnt=%h", i, obs, {stall_cnt, bubble_cnt}, e, {m_stall, m_bubble});
      end
    end
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0; M_icode = NOP; W_icode = NOP;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_normal_flow();
    test_load_use();
    test_mispredict();
    test_ret();
    test_status_passthrough();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] time limit expired");
  end

endmodule
